snn_stdp_engine: RTL

Weight-update responder for the STDP interface of the SNN core. Each `stdp_enable` request carries one timestep's pre (event) and post (spike) bit vectors. The engine decays and bumps the per-input and per-neuron eligibility traces, then scans all F*N synapses, one per clock, applying a clamped trace-based weight delta. It owns the weight RAM's update port; the readback port stays with the core.

---
 rtl/snn_stdp_engine_if.sv | 42 ++++
 rtl/snn_stdp_engine.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/snn_stdp_engine_if.sv
// Request/parameter bundle from the SNN core plus the weight RAM update port.
// slave is the STDP engine; master is the core/RAM side.
interface snn_stdp_engine_if #(
  parameter int F  = 48,
  parameter int N  = 96,
  parameter int AW = $clog2(F*N)
);
  logic                stdp_enable;
  logic [F-1:0]        stdp_pre_bits;
  logic [N-1:0]        stdp_post_bits;
  logic signed [15:0]  stdp_eta;
  logic [7:0]          stdp_eta_shift;
  logic signed [15:0]  stdp_lambda_x;
  logic signed [15:0]  stdp_lambda_y;
  logic signed [15:0]  stdp_b_pre;
  logic signed [15:0]  stdp_b_post;
  logic signed [15:0]  stdp_wmin;
  logic signed [15:0]  stdp_wmax;
  logic                stdp_enable_pre;
  logic                stdp_enable_post;
  logic [AW-1:0]       w_rd_addr;
  logic signed [15:0]  w_rd_data;
  logic                w_we;
  logic [AW-1:0]       w_wr_addr;
  logic signed [15:0]  w_wr_data;
  logic                busy;
  logic                done;

  modport master (
    output stdp_enable, stdp_pre_bits, stdp_post_bits, stdp_eta, stdp_eta_shift,
           stdp_lambda_x, stdp_lambda_y, stdp_b_pre, stdp_b_post, stdp_wmin, stdp_wmax,
           stdp_enable_pre, stdp_enable_post, w_rd_data,
    input  w_rd_addr, w_we, w_wr_addr, w_wr_data, busy, done
  );

  modport slave (
    input  stdp_enable, stdp_pre_bits, stdp_post_bits, stdp_eta, stdp_eta_shift,
           stdp_lambda_x, stdp_lambda_y, stdp_b_pre, stdp_b_post, stdp_wmin, stdp_wmax,
           stdp_enable_pre, stdp_enable_post, w_rd_data,
    output w_rd_addr, w_we, w_wr_addr, w_wr_data, busy, done
  );
endinterface

// File: rtl/snn_stdp_engine.sv
// STDP weight-update engine: decays/bumps eligibility traces, then sweeps all
// F*N synapses one per clock with a clamped trace-based weight delta.
module snn_stdp_engine #(
  parameter int F  = 48,
  parameter int N  = 96,
  parameter int Q  = 14,
  parameter int AW = $clog2(F*N)
) (
  input  logic              clk,
  input  logic              rst,
  snn_stdp_engine_if.slave  bus
);
  localparam int K  = F*N;
  localparam int FW = (F > 1) ? $clog2(F) : 1;
  localparam int NW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, TRACE, SCAN, DRAIN} state_e;

  typedef struct packed {
    logic signed [15:0] eta;
    logic [4:0]         sh;
    logic signed [15:0] lx;
    logic signed [15:0] ly;
    logic signed [15:0] bpre;
    logic signed [15:0] bpost;
    logic signed [15:0] wmin;
    logic signed [15:0] wmax;
    logic               enpre;
    logic               enpost;
  } cfg_t;

  state_e              state_q, state_d;
  cfg_t                cfg_q, cfg_d;
  logic                en_q;
  logic [F-1:0]        pre_q, pre_d, pend_pre_q, pend_pre_d;
  logic [N-1:0]        post_q, post_d, pend_post_q, pend_post_d;
  logic                pend_vld_q, pend_vld_d;
  logic [F-1:0][15:0]  x_q, x_d;
  logic [N-1:0][15:0]  y_q, y_d;
  logic [AW-1:0]       addr_q, addr_d, wr_addr_q, wr_addr_d;
  logic [FW-1:0]       f_q, f_d;
  logic [NW-1:0]       n_q, n_d;
  logic                we_q, we_d, done_q, done_d;
  logic signed [17:0]  dw_q, dw_d;
  logic                req_edge;

  function automatic logic signed [15:0] sat16(input logic signed [32:0] v);
    if (v > 33'sd32767)       return 16'sh7fff;
    else if (v < -33'sd32768) return 16'sh8000;
    else                      return v[15:0];
  endfunction

  function automatic logic signed [15:0] trace_next(input logic signed [15:0] t,
      input logic signed [15:0] lam, input logic signed [15:0] b, input logic hit);
    logic signed [31:0] prod;
    logic signed [32:0] acc;
    prod = 32'(t) * 32'(lam);
    acc  = 33'(sat16(33'(prod >>> Q))) + (hit ? 33'(b) : 33'sd0);
    return sat16(acc);
  endfunction

  assign req_edge = bus.stdp_enable & ~en_q;

  always_comb begin
    state_d     = state_q;
    cfg_d       = cfg_q;
    pre_d       = pre_q;
    post_d      = post_q;
    pend_vld_d  = pend_vld_q;
    pend_pre_d  = pend_pre_q;
    pend_post_d = pend_post_q;
    x_d         = x_q;
    y_d         = y_q;
    addr_d      = addr_q;
    f_d         = f_q;
    n_d         = n_q;
    we_d        = 1'b0;
    wr_addr_d   = wr_addr_q;
    dw_d        = dw_q;
    done_d      = 1'b0;

    // While busy, a new edge only parks its bits; the newest edge wins.
    if (req_edge && state_q != IDLE) begin
      pend_vld_d  = 1'b1;
      pend_pre_d  = bus.stdp_pre_bits;
      pend_post_d = bus.stdp_post_bits;
    end

    case (state_q)
      IDLE: if (req_edge || pend_vld_q) begin
        state_d      = TRACE;
        pre_d        = req_edge ? bus.stdp_pre_bits  : pend_pre_q;
        post_d       = req_edge ? bus.stdp_post_bits : pend_post_q;
        pend_vld_d   = 1'b0;
        cfg_d.eta    = bus.stdp_eta;
        cfg_d.sh     = (bus.stdp_eta_shift > 8'd31) ? 5'd31 : bus.stdp_eta_shift[4:0];
        cfg_d.lx     = bus.stdp_lambda_x;
        cfg_d.ly     = bus.stdp_lambda_y;
        cfg_d.bpre   = bus.stdp_b_pre;
        cfg_d.bpost  = bus.stdp_b_post;
        cfg_d.wmin   = bus.stdp_wmin;
        cfg_d.wmax   = bus.stdp_wmax;
        cfg_d.enpre  = bus.stdp_enable_pre;
        cfg_d.enpost = bus.stdp_enable_post;
      end
      TRACE: begin
        for (int i = 0; i < F; i++) x_d[i] = trace_next(x_q[i], cfg_q.lx, cfg_q.bpre, pre_q[i]);
        for (int j = 0; j < N; j++) y_d[j] = trace_next(y_q[j], cfg_q.ly, cfg_q.bpost, post_q[j]);
        addr_d  = '0;
        f_d     = '0;
        n_d     = '0;
        state_d = SCAN;
      end
      SCAN: begin
        we_d      = 1'b1;
        wr_addr_d = addr_q;
        dw_d      = ((cfg_q.enpost && post_q[n_q]) ? 18'($signed(x_q[f_q])) : 18'sd0)
                  - ((cfg_q.enpre  && pre_q[f_q])  ? 18'($signed(y_q[n_q])) : 18'sd0);
        if (n_q == NW'(N-1)) begin
          n_d = '0;
          f_d = f_q + FW'(1);
        end else begin
          n_d = n_q + NW'(1);
        end
        if (addr_q == AW'(K-1)) begin
          addr_d  = '0;
          state_d = DRAIN;
        end else begin
          addr_d  = addr_q + AW'(1);
        end
      end
      DRAIN: begin
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cfg_q       <= '0;
      en_q        <= 1'b0;
      pre_q       <= '0;
      post_q      <= '0;
      pend_vld_q  <= 1'b0;
      pend_pre_q  <= '0;
      pend_post_q <= '0;
      x_q         <= '0;
      y_q         <= '0;
      addr_q      <= '0;
      f_q         <= '0;
      n_q         <= '0;
      we_q        <= 1'b0;
      wr_addr_q   <= '0;
      dw_q        <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cfg_q       <= cfg_d;
      en_q        <= bus.stdp_enable;
      pre_q       <= pre_d;
      post_q      <= post_d;
      pend_vld_q  <= pend_vld_d;
      pend_pre_q  <= pend_pre_d;
      pend_post_q <= pend_post_d;
      x_q         <= x_d;
      y_q         <= y_d;
      addr_q      <= addr_d;
      f_q         <= f_d;
      n_q         <= n_d;
      we_q        <= we_d;
      wr_addr_q   <= wr_addr_d;
      dw_q        <= dw_d;
      done_q      <= done_d;
    end
  end

  // Write data is formed combinationally from the RAM's registered read data.
  logic signed [33:0] dprod, dsh;
  logic signed [35:0] wsum, wlo;
  logic signed [15:0] wnew;

  always_comb begin
    dprod = 34'($signed(cfg_q.eta)) * 34'(dw_q);
    dsh   = dprod >>> cfg_q.sh;
    wsum  = 36'($signed(bus.w_rd_data)) + 36'(dsh);
    wlo   = (wsum > 36'($signed(cfg_q.wmax))) ? 36'($signed(cfg_q.wmax)) : wsum;
    wnew  = (wlo < 36'($signed(cfg_q.wmin))) ? cfg_q.wmin : wlo[15:0];
  end

  assign bus.w_rd_addr = addr_q;
  assign bus.w_we      = we_q;
  assign bus.w_wr_addr = wr_addr_q;
  assign bus.w_wr_data = we_q ? wnew : 16'sd0;
  assign bus.busy      = (state_q != IDLE) || done_q;
  assign bus.done      = done_q;
endmodule
